// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit: ALUOp classes, ALU control words, FSM states.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        AluOpLsSw   = 2'b00,
        AluOpBranch = 2'b01,
        AluOpRtype  = 2'b10,
        AluOpItype  = 2'b11
    } aluop_e;

    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlMul = 4'b1000;
    localparam logic [3:0] CtrlDiv = 4'b1001;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALUOp/funct decode into an ALU control word plus multi-cycle flags.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned         ALUOP_W   = 2,
    parameter int unsigned         FUNCT_W   = 3,
    parameter int unsigned         CTRL_W    = 4,
    parameter logic [FUNCT_W-1:0]  MUL_FUNCT = 3'b100,
    parameter logic [FUNCT_W-1:0]  DIV_FUNCT = 3'b101
) (
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic               is_multi_o,
    output logic               is_div_o
);

    always_comb begin
        // LW/SW and I-type both fall through to ADD
        ctrl_o     = CTRL_W'(CtrlAdd);
        is_multi_o = 1'b0;
        is_div_o   = 1'b0;
        case (aluop_i)
            ALUOP_W'(AluOpBranch): ctrl_o = CTRL_W'(CtrlSub);
            ALUOP_W'(AluOpRtype): begin
                if (funct_i == MUL_FUNCT) begin
                    ctrl_o     = CTRL_W'(CtrlMul);
                    is_multi_o = 1'b1;
                end else if (funct_i == DIV_FUNCT) begin
                    ctrl_o     = CTRL_W'(CtrlDiv);
                    is_multi_o = 1'b1;
                    is_div_o   = 1'b1;
                end else begin
                    ctrl_o = CTRL_W'(funct_i);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control unit with multi-cycle MUL/DIV stall sequencing and valid/ready handshake.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned         ALUOP_W    = 2,
    parameter int unsigned         FUNCT_W    = 3,
    parameter int unsigned         CTRL_W     = 4,
    parameter logic [FUNCT_W-1:0]  MUL_FUNCT  = 3'b100,
    parameter logic [FUNCT_W-1:0]  DIV_FUNCT  = 3'b101,
    parameter int unsigned         MUL_CYCLES = 4,
    parameter int unsigned         DIV_CYCLES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNCT_W-1:0] funct,
    output logic               ready_out,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic               ctrl_valid,
    output logic               busy,
    output logic               mc_done
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                ctrl_valid_q, ctrl_valid_d;

    logic [CTRL_W-1:0]   dec_ctrl;
    logic                dec_multi;
    logic                dec_div;
    logic                accept;

    alu_ctrl_decode #(
        .ALUOP_W   (ALUOP_W),
        .FUNCT_W   (FUNCT_W),
        .CTRL_W    (CTRL_W),
        .MUL_FUNCT (MUL_FUNCT),
        .DIV_FUNCT (DIV_FUNCT)
    ) u_decode (
        .aluop_i    (ALUOp),
        .funct_i    (funct),
        .ctrl_o     (dec_ctrl),
        .is_multi_o (dec_multi),
        .is_div_o   (dec_div)
    );

    assign ready_out  = (state_q == StIdle);
    assign busy       = (state_q == StBusy);
    assign mc_done    = busy && (cnt_q == '0);
    assign accept     = valid_in && ready_out;
    assign ctrl_out   = ctrl_q;
    assign ctrl_valid = ctrl_valid_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        ctrl_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    ctrl_d       = dec_ctrl;
                    ctrl_valid_d = 1'b1;
                    if (dec_multi) begin
                        state_d = StBusy;
                        cnt_d   = dec_div ? CntW'(DIV_CYCLES - 1) : CntW'(MUL_CYCLES - 1);
                    end
                end
            end
            StBusy: begin
                // Count reaching zero marks the final busy cycle
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
        end
    end

endmodule
